// File: rtl/regfile_param.sv
// Parametrised multi-port register file with self-clearing init sweep.
// Ports: clk, rst_n (sync, active-low), RegWrite/WriteRegister/WriteData
//   write port, ReadRegister/ReadData packed read ports, clear_req
//   re-zero request, init_busy sweep status, wr_dropped discarded-write pulse.
module regfile_param #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_READ = 2,
   parameter int ZERO_EN  = 1,
   parameter int ZERO_IDX = 31,
   parameter int BYPASS   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         RegWrite,
   input  logic [ADDR_W-1:0]            WriteRegister,
   input  logic [DATA_W-1:0]            WriteData,
   input  logic [NUM_READ*ADDR_W-1:0]   ReadRegister,
   output logic [NUM_READ*DATA_W-1:0]   ReadData,
   input  logic                         clear_req,
   output logic                         init_busy,
   output logic                         wr_dropped
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic                r_wr_dropped;
   logic                w_dropped_nxt;
   logic                w_wr_en;
   logic                w_zero_wr;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   // Writes aimed at the hardwired-zero slot vanish without a drop flag.
   assign w_zero_wr = (ZERO_EN != 0) &&
                      (WriteRegister == ADDR_W'(ZERO_IDX));

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_dropped_nxt = 1'b0;
      w_wr_en       = 1'b0;
      unique case (r_state)
         ST_INIT: begin
            w_cnt_nxt     = r_cnt + 1'b1;
            w_dropped_nxt = RegWrite && !w_zero_wr;
            if (r_cnt == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (clear_req) begin
               w_state_nxt   = ST_INIT;
               w_cnt_nxt     = '0;
               w_dropped_nxt = RegWrite && !w_zero_wr;
            end else begin
               w_wr_en = RegWrite && !w_zero_wr;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_INIT;
         r_cnt        <= '0;
         r_wr_dropped <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_wr_dropped <= w_dropped_nxt;
      end
   end

   // Storage is left alone during reset; the sweep zeroes it afterwards.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
         end else if (w_wr_en) begin
            r_mem[WriteRegister] <= WriteData;
         end
      end
   end

   assign init_busy  = (r_state == ST_INIT);
   assign wr_dropped = r_wr_dropped;

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = ReadRegister[p*ADDR_W +: ADDR_W];

      always_comb begin
         w_rd = r_mem[w_ra];
         if (r_state == ST_INIT) begin
            w_rd = '0;
         end else if ((ZERO_EN != 0) && (w_ra == ADDR_W'(ZERO_IDX))) begin
            w_rd = '0;
         end else if ((BYPASS != 0) && RegWrite && !clear_req &&
                      (WriteRegister == w_ra)) begin
            w_rd = WriteData;
         end
      end

      assign ReadData[p*DATA_W +: DATA_W] = w_rd;
   end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default, no-bypass and small builds.
// Table vectors, directed multi-cycle sequences and random stimulus vs model.
module tb_regfile_param;

   logic          clk;
   logic          rstA_n, weA, clrA;
   logic [4:0]    waA;
   logic [63:0]   wdA;
   logic [9:0]    raA;
   logic [127:0]  rdA0, rdA1;
   logic          busyA0, busyA1, dropA0, dropA1;

   logic          rstB_n, weB, clrB;
   logic [3:0]    waB;
   logic [31:0]   wdB;
   logic [11:0]   raB;
   logic [95:0]   rdB;
   logic          busyB, dropB;

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;

   logic [63:0] mm [3][32];
   int          left [3];
   bit          mdrop [3];

   regfile_param dut0 (
      .clk(clk), .rst_n(rstA_n), .RegWrite(weA),
      .WriteRegister(waA), .WriteData(wdA),
      .ReadRegister(raA), .ReadData(rdA0),
      .clear_req(clrA), .init_busy(busyA0), .wr_dropped(dropA0));

   regfile_param #(.BYPASS(0)) dut1 (
      .clk(clk), .rst_n(rstA_n), .RegWrite(weA),
      .WriteRegister(waA), .WriteData(wdA),
      .ReadRegister(raA), .ReadData(rdA1),
      .clear_req(clrA), .init_busy(busyA1), .wr_dropped(dropA1));

   regfile_param #(.DATA_W(32), .ADDR_W(4), .NUM_READ(3),
                   .ZERO_EN(0)) dut2 (
      .clk(clk), .rst_n(rstB_n), .RegWrite(weB),
      .WriteRegister(waB), .WriteData(wdB),
      .ReadRegister(raB), .ReadData(rdB),
      .clear_req(clrB), .init_busy(busyB), .wr_dropped(dropB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int depth_of(int d);
      return (d == 2) ? 16 : 32;
   endfunction

   function automatic bit zen_of(int d);
      return d != 2;
   endfunction

   function automatic bit byp_of(int d);
      return d != 1;
   endfunction

   // Reference: the whole array is wiped when a sweep begins (reads are 0
   // and writes are dropped while it runs, so only its length is visible).
   task automatic model_edge(int d, bit rst, bit we, int wa,
                             logic [63:0] wd, bit clr);
      bit zw;
      bit init;
      zw = zen_of(d) && (wa == 31);
      if (!rst) begin
         left[d]  = depth_of(d);
         mdrop[d] = 0;
         for (int k = 0; k < 32; k++) mm[d][k] = 0;
      end else begin
         init     = left[d] > 0;
         mdrop[d] = we && (init || clr) && !zw;
         if (init) begin
            left[d] = left[d] - 1;
         end else if (clr) begin
            left[d] = depth_of(d);
            for (int k = 0; k < 32; k++) mm[d][k] = 0;
         end else if (we && !zw) begin
            mm[d][wa] = wd;
         end
      end
   endtask

   function automatic logic [63:0] exp_rd(int d, int a, bit we, int wa,
                                          logic [63:0] wd, bit clr);
      if (left[d] > 0) return 64'h0;
      if (zen_of(d) && a == 31) return 64'h0;
      if (byp_of(d) && we && !clr && wa == a) return wd;
      return mm[d][a];
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("A0.rd%0d", p), rdA0[p*64 +: 64],
             exp_rd(0, int'(raA[p*5 +: 5]), weA, int'(waA), wdA, clrA));
         chk($sformatf("A1.rd%0d", p), rdA1[p*64 +: 64],
             exp_rd(1, int'(raA[p*5 +: 5]), weA, int'(waA), wdA, clrA));
      end
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("B.rd%0d", p), {32'h0, rdB[p*32 +: 32]},
             exp_rd(2, int'(raB[p*4 +: 4]), weB, int'(waB),
                    {32'h0, wdB}, clrB));
      end
      chk("A0.busy", 64'(busyA0), 64'(left[0] > 0));
      chk("A1.busy", 64'(busyA1), 64'(left[1] > 0));
      chk("B.busy",  64'(busyB),  64'(left[2] > 0));
      chk("A0.drop", 64'(dropA0), 64'(mdrop[0]));
      chk("A1.drop", 64'(dropA1), 64'(mdrop[1]));
      chk("B.drop",  64'(dropB),  64'(mdrop[2]));
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_on) check_all();
      @(posedge clk);
      model_edge(0, rstA_n, weA, int'(waA), wdA, clrA);
      model_edge(1, rstA_n, weA, int'(waA), wdA, clrA);
      model_edge(2, rstB_n, weB, int'(waB), {32'h0, wdB}, clrB);
      #1;
   endtask

   typedef struct {
      bit          we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [63:0] e0;
      logic [63:0] e0nb;
      logic [63:0] e1;
      bit          edrop;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int n;

      tbl[0] = '{1, 5'd3,  64'hDEAD_BEEF_0123_4567, 5'd3,  5'd4,
                 64'hDEAD_BEEF_0123_4567, 64'h0, 64'h0, 0};
      tbl[1] = '{0, 5'd0,  64'h0, 5'd3, 5'd3,
                 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567,
                 64'hDEAD_BEEF_0123_4567, 0};
      tbl[2] = '{1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31,
                 64'h0, 64'h0, 64'h0, 0};
      tbl[3] = '{0, 5'd0,  64'h0, 5'd31, 5'd31,
                 64'h0, 64'h0, 64'h0, 0};
      tbl[4] = '{1, 5'd7,  64'h1234, 5'd7, 5'd3,
                 64'h1234, 64'h0, 64'hDEAD_BEEF_0123_4567, 0};
      tbl[5] = '{0, 5'd0,  64'h0, 5'd7, 5'd4,
                 64'h1234, 64'h1234, 64'h0, 0};

      rstA_n = 0; weA = 0; clrA = 0; waA = 0; wdA = 0; raA = 0;
      rstB_n = 0; weB = 0; clrB = 0; waB = 0; wdB = 0; raB = 0;

      // Reset sweep with a dropped write on edge 10
      tick();
      tick();
      rstA_n = 1;
      rstB_n = 1;
      chk_on = 1;
      for (int i = 1; i <= 32; i++) begin
         if (i == 10) begin
            weA = 1; waA = 5'd5; wdA = 64'h5555_AAAA_0000_1111;
         end
         tick();
         weA = 0;
         if (i == 10) chk("t1.drop_e10", 64'(dropA0), 64'h1);
         chk($sformatf("t1.busy_e%0d", i), 64'(busyA0), 64'(i < 32));
      end
      for (int a = 0; a < 32; a++) begin
         raA = {5'(a), 5'(a)};
         #1;
         chk($sformatf("t1.zero_x%0d", a), rdA0[63:0], 64'h0);
         tick();
      end

      // Write/read, zero register, bypass via table
      for (int i = 0; i < 6; i++) begin
         weA = tbl[i].we;
         waA = tbl[i].wa;
         wdA = tbl[i].wd;
         raA = {tbl[i].ra1, tbl[i].ra0};
         #2;
         chk($sformatf("tbl%0d.rd0", i), rdA0[63:0], tbl[i].e0);
         chk($sformatf("tbl%0d.rd1", i), rdA0[127:64], tbl[i].e1);
         chk($sformatf("tbl%0d.nb_rd0", i), rdA1[63:0], tbl[i].e0nb);
         chk($sformatf("tbl%0d.drop", i), 64'(dropA0), 64'(tbl[i].edrop));
         tick();
      end
      weA = 0;

      // Clear request with concurrent write and mid-sweep re-request
      weA = 1; waA = 5'd1; wdA = 64'd1; tick();
      weA = 1; waA = 5'd2; wdA = 64'd2; tick();
      weA = 1; waA = 5'd1; wdA = 64'd9; clrA = 1; tick();
      weA = 0; clrA = 0;
      chk("t5.drop", 64'(dropA0), 64'h1);
      chk("t5.busy", 64'(busyA0), 64'h1);
      n = 0;
      while (busyA0 && n < 40) begin
         clrA = (n == 10);
         tick();
         n++;
      end
      clrA = 0;
      chk("t5.sweep_len", 64'(n), 64'd32);
      raA = {5'd2, 5'd1};
      #1;
      chk("t5.x1", rdA0[63:0], 64'h0);
      chk("t5.x2", rdA0[127:64], 64'h0);
      tick();

      // Reset at sweep edge 15
      rstA_n = 0; tick();
      rstA_n = 1;
      for (int i = 1; i <= 14; i++) tick();
      rstA_n = 0; tick();
      rstA_n = 1;
      n = 0;
      while (busyA0 && n < 40) begin
         tick();
         n++;
      end
      chk("t6.sweep_len", 64'(n), 64'd32);

      // Small build: 16-entry sweep, x15 writable, bypass on 3 ports
      clrB = 1; tick();
      clrB = 0;
      n = 0;
      while (busyB && n < 40) begin
         tick();
         n++;
      end
      chk("t6b.sweep_len", 64'(n), 64'd16);
      weB = 1; waB = 4'd15; wdB = 32'hCAFE_F00D;
      raB = {4'd15, 4'd0, 4'd15};
      #1;
      chk("t6b.byp_x15", {32'h0, rdB[31:0]}, 64'hCAFE_F00D);
      chk("t6b.x0", {32'h0, rdB[63:32]}, 64'h0);
      tick();
      weB = 1; waB = 4'd7; wdB = 32'h1234;
      raB = {4'd15, 4'd15, 4'd7};
      #1;
      chk("t6b.byp_x7", {32'h0, rdB[31:0]}, 64'h1234);
      chk("t6b.x15_p1", {32'h0, rdB[63:32]}, 64'hCAFE_F00D);
      chk("t6b.x15_p2", {32'h0, rdB[95:64]}, 64'hCAFE_F00D);
      tick();
      weB = 0;
      raB = {4'd7, 4'd15, 4'd7};
      #1;
      chk("t6b.x7_next", {32'h0, rdB[31:0]}, 64'h1234);
      tick();

      // Random stimulus against the model
      for (int i = 0; i < 600; i++) begin
         rstA_n = ($urandom_range(0, 249) != 0);
         weA    = $urandom_range(0, 1);
         waA    = 5'($urandom_range(0, 31));
         wdA    = {$urandom, $urandom};
         clrA   = ($urandom_range(0, 59) == 0);
         raA[4:0] = $urandom_range(0, 2) == 0 ? waA : 5'($urandom_range(0, 31));
         raA[9:5] = $urandom_range(0, 3) == 0 ? waA : 5'($urandom_range(0, 31));
         rstB_n = ($urandom_range(0, 249) != 0);
         weB    = $urandom_range(0, 1);
         waB    = 4'($urandom_range(0, 15));
         wdB    = $urandom;
         clrB   = ($urandom_range(0, 59) == 0);
         for (int p = 0; p < 3; p++)
            raB[p*4 +: 4] = $urandom_range(0, 2) == 0 ?
                            waB : 4'($urandom_range(0, 15));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
